// File: rtl/trap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trap_pkg : CSR addresses, mstatus fields and sequencer state codes   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package trap_pkg;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_W_EPC    = 4'd1;
  localparam logic [3:0] ST_W_CAUSE  = 4'd2;
  localparam logic [3:0] ST_R_STATUS = 4'd3;
  localparam logic [3:0] ST_W_STATUS = 4'd4;
  localparam logic [3:0] ST_R_TVEC   = 4'd5;
  localparam logic [3:0] ST_TGT      = 4'd6;
  localparam logic [3:0] ST_M_EPC    = 4'd7;
  localparam logic [3:0] ST_M_STATUS = 4'd8;
  localparam logic [3:0] ST_M_WSTAT  = 4'd9;

  typedef logic [3:0] state_t;

  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trap_seq_if : request, CSR port and redirect signals of trap_seq     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface trap_seq_if #(parameter int XLEN = 32);

  logic            exc_valid_i;
  logic [XLEN-1:0] exc_cause_i;
  logic [XLEN-1:0] exc_pc_i;
  logic            mret_i;
  logic            req_ready_o;
  logic [XLEN-1:0] csr_addr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            csr_we_o;
  logic            csr_re_o;
  logic            csr_except_o;
  logic [XLEN-1:0] csr_rdata_i;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    input  exc_valid_i, exc_cause_i, exc_pc_i, mret_i, csr_rdata_i,
    output req_ready_o, csr_addr_o, csr_wdata_o, csr_we_o, csr_re_o,
           csr_except_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    output exc_valid_i, exc_cause_i, exc_pc_i, mret_i, csr_rdata_i,
    input  req_ready_o, csr_addr_o, csr_wdata_o, csr_we_o, csr_re_o,
           csr_except_o, redirect_valid_o, redirect_pc_o
  );

endinterface
`default_nettype wire

// File: rtl/trap_vec_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trap_vec_calc : mtvec + cause -> trap target (TRAP_VECTORED_EN)      |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module trap_vec_calc (
  input  logic [31:0] mtvec_i,
  input  logic [31:0] cause_i,
  output logic [31:0] target_o
);

  logic [31:0] base;
  assign base = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Only interrupts are vectored; the add wraps at 32 bits.
  logic unused_cause_hi;
  assign unused_cause_hi = cause_i[30];
  assign target_o = (mtvec_i[1:0] == 2'b01 && cause_i[31])
                  ? base + {cause_i[29:0], 2'b00}
                  : base;
`else
  logic unused_inputs;
  assign unused_inputs = ^{mtvec_i[1:0], cause_i};
  assign target_o      = base;
`endif

endmodule
`default_nettype wire

// File: rtl/trap_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trap_seq : trap/MRET sequencer driving the machine CSR port          |
// |            optional vectored mode via TRAP_VECTORED_EN               |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module trap_seq
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  trap_seq_if.master bus
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            redirect_valid_q, redirect_valid_d;

  logic [XLEN-1:0] csr_addr, csr_wdata, vec_target;
  logic            csr_we, csr_re;

  trap_vec_calc u_vec_calc (
    .mtvec_i  (bus.csr_rdata_i),
    .cause_i  (cause_q),
    .target_o (vec_target)
  );

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    pc_d             = pc_q;
    mepc_d           = mepc_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = 1'b0;
    csr_addr         = '0;
    csr_wdata        = '0;
    csr_we           = 1'b0;
    csr_re           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Exception has priority; a simultaneous MRET stays pending upstream.
        if (bus.exc_valid_i) begin
          cause_d = bus.exc_cause_i;
          pc_d    = bus.exc_pc_i & ~32'h3;
          state_d = ST_W_EPC;
        end else if (bus.mret_i) begin
          state_d = ST_M_EPC;
        end
      end
      ST_W_EPC: begin
        csr_addr  = CSR_MEPC;
        csr_wdata = pc_q;
        csr_we    = 1'b1;
        state_d   = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
        csr_we    = 1'b1;
        state_d   = ST_R_STATUS;
      end
      ST_R_STATUS: begin
        csr_addr = CSR_MSTATUS;
        csr_re   = 1'b1;
        state_d  = ST_W_STATUS;
      end
      ST_W_STATUS: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mstatus_on_trap(bus.csr_rdata_i);
        csr_we    = 1'b1;
        state_d   = ST_R_TVEC;
      end
      ST_R_TVEC: begin
        csr_addr = CSR_MTVEC;
        csr_re   = 1'b1;
        state_d  = ST_TGT;
      end
      ST_TGT: begin
        redirect_pc_d    = vec_target;
        redirect_valid_d = 1'b1;
        state_d          = ST_IDLE;
      end
      ST_M_EPC: begin
        csr_addr = CSR_MEPC;
        csr_re   = 1'b1;
        state_d  = ST_M_STATUS;
      end
      ST_M_STATUS: begin
        csr_addr = CSR_MSTATUS;
        csr_re   = 1'b1;
        mepc_d   = bus.csr_rdata_i;
        state_d  = ST_M_WSTAT;
      end
      ST_M_WSTAT: begin
        csr_addr         = CSR_MSTATUS;
        csr_wdata        = mstatus_on_mret(bus.csr_rdata_i);
        csr_we           = 1'b1;
        redirect_pc_d    = mepc_q;
        redirect_valid_d = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      cause_q          <= '0;
      pc_q             <= '0;
      mepc_q           <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cause_q          <= cause_d;
      pc_q             <= pc_d;
      mepc_q           <= mepc_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
    end
  end

  // Ready is masked while reset is held so every output reads 0 in reset.
  assign bus.req_ready_o      = (state_q == ST_IDLE) && !rst_i;
  assign bus.csr_except_o     = (state_q != ST_IDLE);
  assign bus.csr_addr_o       = csr_addr;
  assign bus.csr_wdata_o      = csr_wdata;
  assign bus.csr_we_o         = csr_we;
  assign bus.csr_re_o         = csr_re;
  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_trap_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_trap_seq : self-checking bench for trap_seq with a CSR file model |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_trap_seq;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  trap_seq_if #(.XLEN(32)) bus();
  trap_seq #(.XLEN(32)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.master));

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // CSR file: registered read data, resets together with the sequencer.
  logic [31:0] e_mepc, e_mcause, e_mstatus, e_mtvec;
  logic        pre_en = 1'b0;
  logic [31:0] pre_mepc, pre_mcause, pre_mstatus, pre_mtvec;

  function automatic logic [31:0] csr_rd(input logic [31:0] a);
    case (a)
      32'h341: return e_mepc;
      32'h342: return e_mcause;
      32'h300: return e_mstatus;
      32'h305: return e_mtvec;
      default: return 32'hBAD0_0000;
    endcase
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_mepc <= 32'h0; e_mcause <= 32'h0; e_mstatus <= 32'h0; e_mtvec <= 32'h0;
      bus.csr_rdata_i <= 32'h0;
    end else begin
      if (pre_en) begin
        e_mepc <= pre_mepc; e_mcause <= pre_mcause;
        e_mstatus <= pre_mstatus; e_mtvec <= pre_mtvec;
      end else if (bus.csr_we_o) begin
        case (bus.csr_addr_o)
          32'h341: e_mepc    <= bus.csr_wdata_o;
          32'h342: e_mcause  <= bus.csr_wdata_o;
          32'h300: e_mstatus <= bus.csr_wdata_o;
          32'h305: e_mtvec   <= bus.csr_wdata_o;
          default: ;
        endcase
      end
      bus.csr_rdata_i <= bus.csr_re_o ? csr_rd(bus.csr_addr_o) : 32'hDEAD_BEEF;
    end
  end

  // Invariants in every cycle outside reset.
  always @(negedge clk_i) begin
    if (!rst_i)
      chk("we_re_excl_and_except_vs_ready",
          {62'h0, bus.csr_we_o & bus.csr_re_o, bus.csr_except_o ^ bus.req_ready_o}, 64'h1);
  end

  // ---------------- reference model ----------------
  logic [31:0] m_mepc, m_mcause, m_mstatus, m_mtvec, exp_tgt;

  typedef struct {
    bit          busy;
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          rv;
  } cyc_t;
  cyc_t exp_q[$];

  function automatic cyc_t mk(bit busy, bit we, bit re, logic [31:0] addr, logic [31:0] wd, bit rv);
    cyc_t c;
    c.busy = busy; c.we = we; c.re = re; c.addr = addr; c.wdata = wd; c.rv = rv;
    return c;
  endfunction

  function automatic logic [31:0] trap_st(input logic [31:0] s);
    return (s & ~32'h0000_1888) | 32'h0000_1800 | (s[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] mret_st(input logic [31:0] s);
    return (s & ~32'h0000_0088) | 32'h80 | (s[7] ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = tvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
    if (tvec[1:0] == 2'b01 && cause[31]) return base + (cause & 32'h7FFF_FFFF) * 32'd4;
`endif
    return base;
  endfunction

  function automatic void build_trap(input logic [31:0] cause, input logic [31:0] pc);
    logic [31:0] nst;
    exp_q.delete();
    m_mepc   = pc & 32'hFFFF_FFFC;
    m_mcause = cause;
    nst      = trap_st(m_mstatus);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h341, m_mepc, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h342, cause, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h300, nst, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h305, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
    m_mstatus = nst;
    exp_tgt   = m_target(m_mtvec, cause);
  endfunction

  function automatic void build_mret();
    logic [31:0] nst;
    exp_q.delete();
    nst = mret_st(m_mstatus);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h341, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h300, nst, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
    m_mstatus = nst;
    exp_tgt   = m_mepc;
  endfunction

  // Called on a negedge in an IDLE cycle: that cycle is the accept cycle.
  task automatic start_req(input bit is_mret, input logic [31:0] cause, input logic [31:0] pc);
    bus.exc_valid_i = !is_mret;
    bus.mret_i      = is_mret;
    bus.exc_cause_i = cause;
    bus.exc_pc_i    = pc;
    chk("ready_at_request", {63'h0, bus.req_ready_o}, 64'h1);
    if (is_mret) build_mret();
    else         build_trap(cause, pc);
  endtask

  task automatic run_seq(input bit keep_exc, input bit keep_mret,
                         input logic [31:0] ncause, input logic [31:0] npc, input int ncyc);
    cyc_t e;
    for (int i = 0; i < exp_q.size() && i < ncyc; i++) begin
      e = exp_q[i];
      @(negedge clk_i);
      if (i == 0) begin
        if (keep_exc) begin
          bus.exc_cause_i = ncause;
          bus.exc_pc_i    = npc;
        end else begin
          bus.exc_valid_i = 1'b0;
        end
        if (!keep_mret) bus.mret_i = 1'b0;
      end
      chk($sformatf("ctrl_cycle%0d", i + 1),
          {59'h0, bus.csr_except_o, bus.req_ready_o, bus.csr_we_o, bus.csr_re_o, bus.redirect_valid_o},
          {59'h0, e.busy, !e.busy, e.we, e.re, e.rv});
      if (e.we || e.re || !e.busy)
        chk($sformatf("addr_cycle%0d", i + 1), {32'h0, bus.csr_addr_o}, {32'h0, e.addr});
      if (e.we || !e.busy)
        chk($sformatf("wdata_cycle%0d", i + 1), {32'h0, bus.csr_wdata_o}, {32'h0, e.wdata});
      if (e.rv)
        chk("redirect_pc_model", {32'h0, bus.redirect_pc_o}, {32'h0, exp_tgt});
    end
  endtask

  task automatic preload(input logic [31:0] epc, input logic [31:0] cause,
                         input logic [31:0] st, input logic [31:0] tvec);
    pre_mepc = epc; pre_mcause = cause; pre_mstatus = st; pre_mtvec = tvec;
    pre_en = 1'b1;
    @(negedge clk_i);
    pre_en = 1'b0;
    m_mepc = epc; m_mcause = cause; m_mstatus = st; m_mtvec = tvec;
  endtask

  typedef struct {
    bit          is_mret;
    bit          pre;
    logic [31:0] p_mstatus, p_mtvec, cause, pc;
    logic [31:0] x_tgt, x_mepc, x_mcause, x_mstatus;
  } vec_t;
  vec_t tv[4];

  initial begin
    logic [31:0] rc, rp, rt;
    int          r;

    tv[0] = '{1'b0, 1'b1, 32'h8, 32'h8000, 32'h2, 32'h1006, 32'h8000, 32'h1004, 32'h2, 32'h1880};
    tv[1] = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1004, 32'h1004, 32'h2, 32'h1888};
`ifdef TRAP_VECTORED_EN
    tv[2] = '{1'b0, 1'b1, 32'h0, 32'h8001, 32'h8000_0007, 32'h2000, 32'h801C, 32'h2000, 32'h8000_0007, 32'h1800};
`else
    tv[2] = '{1'b0, 1'b1, 32'h0, 32'h8001, 32'h8000_0007, 32'h2000, 32'h8000, 32'h2000, 32'h8000_0007, 32'h1800};
`endif
    tv[3] = '{1'b0, 1'b1, 32'h1888, 32'h8001, 32'h5, 32'h3002, 32'h8000, 32'h3000, 32'h5, 32'h1880};

    bus.exc_valid_i = 1'b0; bus.mret_i = 1'b0;
    bus.exc_cause_i = 32'h0; bus.exc_pc_i = 32'h0;
    m_mepc = 32'h0; m_mcause = 32'h0; m_mstatus = 32'h0; m_mtvec = 32'h0; exp_tgt = 32'h0;

    repeat (2) @(negedge clk_i);
    chk("reset_ctrl", {59'h0, bus.req_ready_o, bus.csr_except_o, bus.csr_we_o, bus.csr_re_o,
                       bus.redirect_valid_o}, 64'h0);
    chk("reset_addr_wdata", {bus.csr_addr_o, bus.csr_wdata_o}, 64'h0);
    chk("reset_redirect_pc", {32'h0, bus.redirect_pc_o}, 64'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 4; i++) begin
      if (tv[i].pre) preload(32'h0, 32'h0, tv[i].p_mstatus, tv[i].p_mtvec);
      start_req(tv[i].is_mret, tv[i].cause, tv[i].pc);
      run_seq(1'b0, 1'b0, 32'h0, 32'h0, 99);
      chk($sformatf("tv%0d_redirect", i), {32'h0, bus.redirect_pc_o}, {32'h0, tv[i].x_tgt});
      chk($sformatf("tv%0d_mepc", i), {32'h0, e_mepc}, {32'h0, tv[i].x_mepc});
      chk($sformatf("tv%0d_mcause", i), {32'h0, e_mcause}, {32'h0, tv[i].x_mcause});
      chk($sformatf("tv%0d_mstatus", i), {32'h0, e_mstatus}, {32'h0, tv[i].x_mstatus});
    end

    // Exception and MRET together: trap first, MRET accepted in the redirect cycle.
    preload(32'h0, 32'h0, 32'h8, 32'h8000);
    start_req(1'b0, 32'hB, 32'h4000);
    bus.mret_i = 1'b1;
    run_seq(1'b0, 1'b1, 32'h0, 32'h0, 99);
    build_mret();
    run_seq(1'b0, 1'b0, 32'h0, 32'h0, 99);
    chk("simul_mret_redirect", {32'h0, bus.redirect_pc_o}, 64'h4000);
    chk("simul_mstatus", {32'h0, e_mstatus}, 64'h1888);

    // Request held (with new payload) across a busy sequence.
    preload(32'h0, 32'h0, 32'h0, 32'h9000);
    start_req(1'b0, 32'h3, 32'h5000);
    run_seq(1'b1, 1'b0, 32'h4, 32'h5008, 99);
    build_trap(32'h4, 32'h5008);
    run_seq(1'b0, 1'b0, 32'h0, 32'h0, 99);
    chk("held_mcause", {32'h0, e_mcause}, 64'h4);
    chk("held_mepc", {32'h0, e_mepc}, 64'h5008);

    // Reset asserted while in W_STATUS.
    start_req(1'b0, 32'h6, 32'h6000);
    run_seq(1'b0, 1'b0, 32'h0, 32'h0, 4);
    #2 rst_i = 1'b1;
    #1;
    chk("midreset_ctrl", {59'h0, bus.req_ready_o, bus.csr_except_o, bus.csr_we_o, bus.csr_re_o,
                          bus.redirect_valid_o}, 64'h0);
    chk("midreset_addr_wdata", {bus.csr_addr_o, bus.csr_wdata_o}, 64'h0);
    chk("midreset_redirect_pc", {32'h0, bus.redirect_pc_o}, 64'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    m_mepc = 32'h0; m_mcause = 32'h0; m_mstatus = 32'h0; m_mtvec = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      chk("post_reset_idle", {61'h0, bus.req_ready_o, bus.csr_except_o, bus.redirect_valid_o}, 64'h4);
    end

    // Randomized traffic against the model, mostly back-to-back.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 5);
      if (r == 0) begin
        rt = $urandom();
        if ($urandom_range(0, 1) == 1) rt[1:0] = 2'b01;
        rc = $urandom();
        rp = $urandom();
        preload(rp, rc, $urandom(), rt);
      end else if (r == 1) begin
        @(negedge clk_i);
      end
      rc = $urandom();
      if ($urandom_range(0, 1) == 1) rc = 32'h8000_0000 | 32'($urandom_range(0, 15));
      rp = $urandom();
      start_req($urandom_range(0, 2) == 0, rc, rp);
      run_seq(1'b0, 1'b0, 32'h0, 32'h0, 99);
      chk("rand_mepc", {32'h0, e_mepc}, {32'h0, m_mepc});
      chk("rand_mstatus", {32'h0, e_mstatus}, {32'h0, m_mstatus});
    end

    @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
